// File: rtl/packet_tx_pkg.sv
// Shared types and widths for the packet transmitter.
// The FSM state encoding lives here so all files agree on it.
package packet_tx_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSize,
        StStart,
        StData,
        StCksum
    } tx_state_e;

endpackage

// File: rtl/packet_tx_if.sv
// Request, word-source and framed-output signals of packet_tx in one bundle.
// The slave modport is the transmitter; the master modport is its environment.
interface packet_tx_if;
    import packet_tx_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [SIZE_W-1:0] req_size;
    logic              src_rd;
    logic [DATA_W-1:0] src_data;
    logic              size_valid;
    logic [SIZE_W-1:0] size;
    logic              data_start;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              cksum_valid;

    modport master (
        output req_valid, req_size, src_data,
        input  req_ready, src_rd, size_valid, size, data_start, dout, dout_valid,
        input  cksum_valid
    );

    modport slave (
        input  req_valid, req_size, src_data,
        output req_ready, src_rd, size_valid, size, data_start, dout, dout_valid,
        output cksum_valid
    );

endinterface

// File: rtl/packet_tx_cksum_acc.sv
// Payload checksum: running 32-bit sum of accepted words, carries dropped.
// A clear takes priority over an add in the same cycle.
module cksum_acc
    import packet_tx_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (add_en) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum = r_sum;

endmodule

// File: rtl/packet_tx.sv
// Packet transmitter: announces a size, marks the payload start, streams the
// source words and closes with their checksum. All outputs except req_ready are registered.
module packet_tx
    import packet_tx_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    packet_tx_if.slave  io_bus
);

    tx_state_e         r_state;
    logic [SIZE_W-1:0] r_size_cap;
    logic [SIZE_W-1:0] r_rd_left;
    logic [SIZE_W-1:0] r_words_left;
    logic              r_src_rd;
    logic              r_rd_d;
    logic              r_size_valid;
    logic [SIZE_W-1:0] r_size_out;
    logic              r_data_start;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_cksum_valid;

    logic              w_capture;
    logic [DATA_W-1:0] w_sum;

    assign w_capture = (r_state == StIdle) && io_bus.req_valid;

    // r_rd_d marks the cycle in which src_data holds a requested word.
    cksum_acc u_cksum_acc (
        .clock  (clock),
        .rst_n  (rst_n),
        .clear  (w_capture),
        .add_en (r_rd_d),
        .din    (io_bus.src_data),
        .sum    (w_sum)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_size_cap    <= '0;
            r_rd_left     <= '0;
            r_words_left  <= '0;
            r_src_rd      <= 1'b0;
            r_rd_d        <= 1'b0;
            r_size_valid  <= 1'b0;
            r_size_out    <= '0;
            r_data_start  <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_cksum_valid <= 1'b0;
        end else begin
            r_size_valid  <= 1'b0;
            r_size_out    <= '0;
            r_data_start  <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_cksum_valid <= 1'b0;
            r_src_rd      <= 1'b0;
            r_rd_d        <= r_src_rd;

            if (r_rd_d) begin
                r_dout       <= io_bus.src_data;
                r_dout_valid <= 1'b1;
            end

            // Reads run back to back from the SIZE cycle until the count is spent.
            if (r_state != StIdle && r_rd_left != '0) begin
                r_src_rd  <= 1'b1;
                r_rd_left <= r_rd_left - SIZE_W'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (io_bus.req_valid) begin
                        r_state      <= StSize;
                        r_size_cap   <= io_bus.req_size;
                        r_words_left <= io_bus.req_size;
                        r_size_valid <= 1'b1;
                        r_size_out   <= io_bus.req_size;
                        if (io_bus.req_size != '0) begin
                            r_src_rd  <= 1'b1;
                            r_rd_left <= io_bus.req_size - SIZE_W'(1);
                        end else begin
                            r_rd_left <= '0;
                        end
                    end
                end
                StSize: begin
                    r_state      <= StStart;
                    r_data_start <= 1'b1;
                end
                StStart: begin
                    if (r_size_cap != '0) begin
                        r_state <= StData;
                    end else begin
                        r_state       <= StCksum;
                        r_dout        <= w_sum;
                        r_cksum_valid <= 1'b1;
                    end
                end
                StData: begin
                    r_words_left <= r_words_left - SIZE_W'(1);
                    if (r_words_left == SIZE_W'(1)) begin
                        r_state       <= StCksum;
                        r_dout        <= w_sum;
                        r_dout_valid  <= 1'b0;
                        r_cksum_valid <= 1'b1;
                    end
                end
                StCksum: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.req_ready   = (r_state == StIdle);
    assign io_bus.src_rd      = r_src_rd;
    assign io_bus.size_valid  = r_size_valid;
    assign io_bus.size        = r_size_out;
    assign io_bus.data_start  = r_data_start;
    assign io_bus.dout        = r_dout;
    assign io_bus.dout_valid  = r_dout_valid;
    assign io_bus.cksum_valid = r_cksum_valid;

endmodule

// File: tb/tb_packet_tx.sv
// Scoreboard bench for packet_tx: stimulus queues timed expected events, a
// negedge monitor pops and compares them and runs a size/data_start receiver model.
module tb_packet_tx;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    packet_tx_if bus ();

    packet_tx dut (
        .clock  (clock),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clock = ~clock;

    typedef enum int {EvSize, EvStart, EvData, EvCksum} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] src_q[$];
    logic [31:0] wbuf[128];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic want_zero = 1'b0;

    logic [31:0] rx_left = '0;
    logic        rx_armed = 1'b0;
    logic        rx_fire;

    ev_t  got;
    ev_t  want;
    int   nflags;
    logic [5:0] flags;

    always @(posedge clock) cyc <= cyc + 1;

    // Word source with a fixed one-cycle read latency.
    always @(posedge clock) begin
        if (bus.src_rd && src_q.size() > 0) bus.src_data <= src_q.pop_front();
        else bus.src_data <= 32'hA5A5_5A5A;
    end

    // Downstream receiver: loads on size_valid, counts payload after data_start.
    always @(posedge clock) begin
        if (!rst_n) begin
            rx_armed <= 1'b0;
            rx_left  <= '0;
        end else begin
            if (bus.size_valid) rx_left <= bus.size;
            if (bus.data_start) rx_armed <= 1'b1;
            else if (rx_fire) rx_armed <= 1'b0;
            else if (rx_armed && bus.dout_valid) rx_left <= rx_left - 32'd1;
        end
    end
    assign rx_fire = rx_armed && (rx_left == 32'd0);

    task automatic chk(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clock) begin
        flags = {bus.size_valid, bus.data_start, bus.dout_valid, bus.cksum_valid,
                 bus.src_rd, bus.req_ready};
        nflags = int'(bus.size_valid) + int'(bus.data_start) + int'(bus.dout_valid)
                 + int'(bus.cksum_valid);
        if (want_zero) begin
            chk("reset_flags", flags == 6'b000001, 32'(flags), 32'h1);
            chk("reset_size", bus.size == 32'd0, bus.size, 32'd0);
            chk("reset_dout", bus.dout == 32'd0, bus.dout, 32'd0);
        end
        if (nflags > 0) chk("exclusive_flags", nflags == 1, 32'(nflags), 32'd1);
        if (!bus.size_valid) chk("size_idle_zero", bus.size == 32'd0, bus.size, 32'd0);
        if (!bus.dout_valid && !bus.cksum_valid)
            chk("dout_idle_zero", bus.dout == 32'd0, bus.dout, 32'd0);
        if (nflags == 1) begin
            got.cyc = cyc;
            if (bus.size_valid) begin got.kind = EvSize; got.data = bus.size; end
            else if (bus.data_start) begin got.kind = EvStart; got.data = 32'd0; end
            else if (bus.dout_valid) begin got.kind = EvData; got.data = bus.dout; end
            else begin got.kind = EvCksum; got.data = bus.dout; end
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, none due",
                         got.kind, got.data, got.cyc);
            end else begin
                want = exp_q.pop_front();
                if (got.kind == want.kind && got.cyc == want.cyc && got.data == want.data)
                    n_pass++;
                else
                    $display("FAIL event: got kind %0d data %h cycle %0d, required kind %0d data %h cycle %0d",
                             got.kind, got.data, got.cyc, want.kind, want.data, want.cyc);
            end
        end
        if (bus.src_rd) chk("src_rd_allowed", src_q.size() > 0, 32'(src_q.size()), 32'd1);
        if (rx_fire || bus.cksum_valid)
            chk("rx_coincide", rx_fire == bus.cksum_valid, 32'(rx_fire), 32'(bus.cksum_valid));
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d, required below 20000", cyc);
            $fatal(1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] sz, output int s);
        int guard = 0;
        while (!bus.req_ready) begin
            tick();
            guard++;
            if (guard > 1000) begin
                $display("FAIL req_ready_timeout: got 0, required 1");
                $fatal(1);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_size  = sz;
        s = cyc + 1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic push_ev(input ev_kind_e k, input int c, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_xfer(input int s, input int n, input logic [31:0] ck);
        push_ev(EvSize, s, 32'(n));
        push_ev(EvStart, s + 1, 32'd0);
        for (int k = 1; k <= n; k++) begin
            push_ev(EvData, s + 1 + k, wbuf[k-1]);
            src_q.push_back(wbuf[k-1]);
        end
        push_ev(EvCksum, s + n + 2, ck);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0) begin
            tick();
            guard++;
            if (guard > 500) begin
                $display("FAIL drain_timeout: got %0d pending events, required 0", exp_q.size());
                $fatal(1);
            end
        end
        repeat (3) tick();
    endtask

    initial begin
        int s;
        int s1;
        logic [31:0] ck;
        int sizes[4] = '{0, 1, 7, 100};

        bus.req_valid = 1'b0;
        bus.req_size  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        want_zero = 1'b1;
        tick();
        want_zero = 1'b0;

        // size 3, words 1,2,3 -> checksum 6
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
        issue(32'd3, s);
        push_xfer(s, 3, 32'd6);
        drain();

        // size 0 -> no reads, checksum 0 at S+2
        issue(32'd0, s);
        push_xfer(s, 0, 32'd0);
        drain();

        // carry is discarded: 0xFFFFFFFF + 2 = 1
        wbuf[0] = 32'hFFFF_FFFF; wbuf[1] = 32'h0000_0002;
        issue(32'd2, s);
        push_xfer(s, 2, 32'h0000_0001);
        drain();

        // back-to-back with req_valid held: second size_valid 5 cycles later
        while (!bus.req_ready) tick();
        bus.req_valid = 1'b1;
        bus.req_size  = 32'd1;
        s1 = cyc + 1;
        tick();
        bus.req_size = 32'd2;
        wbuf[0] = 32'h11;
        push_xfer(s1, 1, 32'h11);
        wbuf[0] = 32'h22; wbuf[1] = 32'h33;
        push_xfer(s1 + 5, 2, 32'h55);
        while (cyc < s1 + 5) tick();
        bus.req_valid = 1'b0;
        drain();

        // req_valid pulse during DATA is ignored
        wbuf[0] = 32'd7; wbuf[1] = 32'd8; wbuf[2] = 32'd9;
        issue(32'd3, s);
        push_xfer(s, 3, 32'd24);
        while (cyc < s + 3) tick();
        bus.req_valid = 1'b1;
        bus.req_size  = 32'd9;
        tick();
        bus.req_valid = 1'b0;
        drain();
        repeat (10) tick();

        // reset at T+2 of a size-5 transfer: only two payload words, no checksum
        for (int k = 0; k < 5; k++) wbuf[k] = 32'd10 + 32'(k);
        issue(32'd5, s);
        push_ev(EvSize, s, 32'd5);
        push_ev(EvStart, s + 1, 32'd0);
        push_ev(EvData, s + 2, wbuf[0]);
        push_ev(EvData, s + 3, wbuf[1]);
        for (int k = 0; k < 5; k++) src_q.push_back(wbuf[k]);
        while (cyc < s + 3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        src_q.delete();
        want_zero = 1'b1;
        tick();
        want_zero = 1'b0;
        repeat (20) tick();
        drain();

        // loopback sizes against the receiver model
        foreach (sizes[i]) begin
            ck = '0;
            for (int k = 0; k < sizes[i]; k++) begin
                wbuf[k] = 32'h1357_9BDF * 32'(k + 1) + 32'(i);
                ck = ck + wbuf[k];
            end
            issue(32'(sizes[i]), s);
            push_xfer(s, sizes[i], ck);
            drain();
        end

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_tx.md
PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 The block SHALL have these ports: clock, input, 1, rising-edge clock.
REQ-002 The block SHALL have these ports: rst_n, input, 1, reset; synchronous, active-low.
REQ-003 The block SHALL have these ports: req_valid, input, 1, transfer request.
REQ-004 The block SHALL have these ports: req_ready, output, 1, high only in IDLE.
REQ-005 The block SHALL have these ports: req_size, input, 32, word count of the requested transfer.
REQ-006 The block SHALL have these ports: src_rd, output, 1, read strobe to the word source.
REQ-007 The block SHALL have these ports: src_data, input, 32, source word, valid one cycle after src_rd (fixed latency 1).
REQ-008 The block SHALL have these ports: size_valid, output, 1, one-cycle size announcement.
REQ-009 The block SHALL have these ports: size, output, 32, captured req_size, driven while size_valid is high, else 0.
REQ-010 The block SHALL have these ports: data_start, output, 1, one-cycle payload start marker.
REQ-011 The block SHALL have these ports: dout, output, 32, payload word or checksum, else 0.
REQ-012 The block SHALL have these ports: dout_valid, output, 1, dout carries a payload word.
REQ-013 The block SHALL have these ports: cksum_valid, output, 1, dout carries the checksum; this is the transfer-complete pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, SIZE, START, DATA and CKSUM.
REQ-015 In IDLE, req_valid=1 SHALL capture req_size and load the remaining-read and remaining-word counters. The next state SHALL be SIZE.
REQ-016 In SIZE (cycle S), size_valid SHALL be 1 and size SHALL equal the captured value. The next state SHALL be START.
REQ-017 In START (cycle T=S+1), data_start SHALL be 1. The next state SHALL be DATA if the size is greater than 0, else CKSUM.
REQ-018 src_rd SHALL be asserted from cycle S onward, exactly size times, on consecutive cycles, ending at cycle S+size-1. src_rd SHALL never be asserted when size=0.
REQ-019 Each returned src_data SHALL be registered into dout, so payload word k (k=1..size) appears at cycle T+k with dout_valid=1.
REQ-020 DATA SHALL last exactly size cycles with no gaps; the payload stream has no backpressure.
REQ-021 In CKSUM (cycle T+size+1), cksum_valid SHALL be 1, dout SHALL equal the checksum and dout_valid SHALL be 0. The next state SHALL be IDLE.
REQ-022 The checksum SHALL be the sum of all payload words modulo 2^32, with carries discarded. The accumulator SHALL be cleared on request capture.
REQ-023 With these timings, a downstream size/data_start down-counter receiver SHALL raise its checksum_valid in the same cycle as cksum_valid.
REQ-024 req_ready SHALL be 1 only in IDLE. req_valid outside IDLE SHALL be ignored and SHALL NOT corrupt the captured size.
REQ-025 A new request SHALL be accepted in the first IDLE cycle after CKSUM, giving a minimum request-to-request spacing of size+4 cycles.
REQ-026 size=0xFFFFFFFF SHALL be legal; the counters SHALL be 32-bit and SHALL NOT wrap.
REQ-027 size_valid, data_start, dout_valid and cksum_valid SHALL be mutually exclusive in every cycle.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE. It SHALL clear the counters, the captured size and the checksum accumulator. It SHALL drive all outputs to 0, except req_ready, which SHALL be 1 from the first cycle after reset.
REQ-029 Reset in any state, including mid-DATA, SHALL abort the transfer. No cksum_valid SHALL be produced for the aborted transfer.

Structure
REQ-030 The shared package SHALL hold the state enumeration and the constants DATA_W=32 and SIZE_W=32.
REQ-031 The checksum accumulator SHALL be one sub-module, cksum_acc, with ports clear, add_en, din and sum.
REQ-032 All outputs SHALL be registered except req_ready, which SHALL be decoded from state.

Verification
REQ-033 Scenario: size=3, source words 1, 2, 3. Required response: size_valid at S, data_start at S+1, dout 1/2/3 at S+2..S+4, cksum_valid with dout=6 at S+5.
REQ-034 Scenario: size=0. Required response: no src_rd, data_start at S+1, cksum_valid with dout=0 at S+2.
REQ-035 Scenario: size=2, words 0xFFFFFFFF and 0x00000002. Required response: checksum 0x00000001.
REQ-036 Scenario: back-to-back requests of size 1 then size 2, with req_valid held high. Required response: second size_valid 5 cycles after the first; a req_valid pulse during DATA is ignored.
REQ-037 Scenario: rst_n low at T+2 of a size-5 transfer. Required response: all outputs 0 the next cycle, no cksum_valid, req_ready=1.
REQ-038 Scenario: loopback into the size/data_start counting receiver for sizes 0, 1, 7 and 100. Required response: the receiver's checksum_valid coincides with cksum_valid every time.
